cache_ctrl_v6: RTL and testbench



---
 rtl/cache_ctrl_v6.sv | 192 +++++++++++++++++++
 tb/tb_cache_ctrl_v6.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_v6.sv
// ============================================================================
// cache_ctrl_v6
// Miss-handling controller for a 2-way, set-associative data cache with
// 64-byte lines. Keeps tag/valid/dirty/LRU state and resolves hit or miss for
// each CPU SRAM-port request. On a miss it writes back a dirty victim, then
// refills the line through a line-granular memory bridge. The pipeline is
// stalled until the held request can hit.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   sram_en           CPU request valid (held stable while stallreq is high)
//   sram_wen[3:0]     byte write enables; nonzero means a store
//   sram_addr[31:0]   request address: tag = [31:12], index = [11:6]
//   stallreq          pipeline stall
//   hit[1:0]          one-hot way hit, to the data array
//   lru               victim way select, to the data array (1 = way1)
//   cached            request is cacheable (not in the 0xA000_0000 segment)
//   write_back        one-cycle pulse: data array reads out the victim line
//   refresh           one-cycle pulse: data array writes the refill line
//   wr_req/wr_addr    victim line write to the bridge; wr_ack ends it
//   rd_req/rd_addr    refill line read from the bridge; rd_ack ends it
// ============================================================================
module cache_ctrl_v6 #(
    parameter int TAG_W = 20,
    parameter int SETS  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    output logic        stallreq,
    output logic [1:0]  hit,
    output logic        lru,
    output logic        cached,
    output logic        write_back,
    output logic        refresh,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    input  logic        wr_ack,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_ack
);
    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB_READ,
        S_WB_REQ,
        S_RD_REQ
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Per-set state. Tags carry no reset; valid bits guard every use.
    logic [TAG_W-1:0] r_tag   [2][SETS];
    logic [SETS-1:0]  r_valid [2];
    logic [SETS-1:0]  r_dirty [2];
    logic [SETS-1:0]  r_lru;

    // Miss context captured in the detect cycle.
    logic             r_victim;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag_req;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_rd_addr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_cached;
    logic [1:0]       w_hit;
    logic             w_miss;
    logic             w_vict;
    logic             w_vict_dirty;
    logic             w_refresh;
    logic             w_unused;

    assign w_idx    = sram_addr[6 +: IDX_W];
    assign w_tag    = sram_addr[31 -: TAG_W];
    assign w_cached = (sram_addr[31:29] != 3'b101);
    assign w_unused = ^sram_addr[5:0];

    // Lookup is only live in IDLE; a held request replays here after refill.
    always_comb begin
        w_hit  = 2'b00;
        w_miss = 1'b0;
        if (r_state == S_IDLE && sram_en && w_cached) begin
            for (int w = 0; w < 2; w++) begin
                w_hit[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
            end
            w_miss = (w_hit == 2'b00);
        end
    end

    assign w_vict       = r_lru[w_idx];
    assign w_vict_dirty = r_valid[w_vict][w_idx] & r_dirty[w_vict][w_idx];

    // Next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        stallreq    = 1'b1;
        hit         = 2'b00;
        lru         = r_victim;
        write_back  = 1'b0;
        wr_req      = 1'b0;
        rd_req      = 1'b0;
        w_refresh   = 1'b0;
        case (r_state)
            S_IDLE: begin
                stallreq = w_miss;
                hit      = w_hit;
                lru      = r_lru[w_idx];
                if (w_miss) begin
                    w_state_nxt = w_vict_dirty ? S_WB_READ : S_RD_REQ;
                end
            end
            S_WB_READ: begin
                write_back  = 1'b1;
                w_state_nxt = S_WB_REQ;
            end
            S_WB_REQ: begin
                wr_req = 1'b1;
                if (wr_ack) begin
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                rd_req = 1'b1;
                if (rd_ack) begin
                    w_refresh   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cached  = w_cached;
    assign refresh = w_refresh;
    assign wr_addr = r_wr_addr;
    assign rd_addr = r_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
            r_lru      <= '0;
            r_victim   <= 1'b0;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hit != 2'b00) begin
                // Hit on way0 makes way1 the next victim, and vice versa.
                r_lru[w_idx] <= w_hit[0];
                if (sram_wen != 4'b0000) begin
                    if (w_hit[0]) r_dirty[0][w_idx] <= 1'b1;
                    if (w_hit[1]) r_dirty[1][w_idx] <= 1'b1;
                end
            end
            if (w_miss) begin
                r_victim  <= w_vict;
                r_rd_addr <= {w_tag, w_idx, 6'b0};
                // Only a dirty victim has a meaningful old tag to write back.
                if (w_vict_dirty) begin
                    r_wr_addr <= {r_tag[w_vict][w_idx], w_idx, 6'b0};
                end
            end
            if (w_refresh) begin
                r_valid[r_victim][r_idx] <= 1'b1;
                r_dirty[r_victim][r_idx] <= 1'b0;
                r_lru[r_idx]             <= ~r_victim;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_miss) begin
            r_idx     <= w_idx;
            r_tag_req <= w_tag;
        end
        if (!rst && w_refresh) begin
            r_tag[r_victim][r_idx] <= r_tag_req;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_v6.sv
module tb_cache_ctrl_v6;
    logic        clk;
    logic        rst;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic        stallreq;
    logic [1:0]  hit;
    logic        lru;
    logic        cached;
    logic        write_back;
    logic        refresh;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_ack;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ack;

    int checks = 0;
    int errors = 0;

    cache_ctrl_v6 dut (
        .clk        (clk),
        .rst        (rst),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .stallreq   (stallreq),
        .hit        (hit),
        .lru        (lru),
        .cached     (cached),
        .write_back (write_back),
        .refresh    (refresh),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic        wack;
        logic        rack;
        logic        stall;
        logic [1:0]  hit;
        logic        lru;
        logic        cached;
        logic        wb;
        logic        rf;
        logic        wrq;
        logic        rdq;
        logic [31:0] wa;
        logic [31:0] ra;
    } vec_t;

    typedef struct {
        int          stall;
        int          wb;
        int          wrq;
        int          rf;
        int          both;
        logic        lru_wb;
        logic        lru_rf;
        logic [31:0] wa;
        logic [31:0] ra;
        logic [1:0]  hit;
        logic        done;
    } res_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                                input logic wack, input logic rack,
                                input logic stall, input logic [1:0] h, input logic l,
                                input logic c, input logic wb, input logic rf,
                                input logic wrq, input logic rdq,
                                input logic [31:0] wa, input logic [31:0] ra);
        vec_t v;
        v.en = en; v.wen = wen; v.addr = addr; v.wack = wack; v.rack = rack;
        v.stall = stall; v.hit = h; v.lru = l; v.cached = c; v.wb = wb; v.rf = rf;
        v.wrq = wrq; v.rdq = rdq; v.wa = wa; v.ra = ra;
        return v;
    endfunction

    // Drives one request until stallreq drops, acking wr_req after wdly extra
    // cycles and rd_req after rdly extra cycles, and records what was seen.
    task automatic run_req(input logic [31:0] addr, input logic [3:0] wen,
                           input int wdly, input int rdly, output res_t r);
        int wcnt;
        int rcnt;
        wcnt = 0; rcnt = 0;
        r.stall = 0; r.wb = 0; r.wrq = 0; r.rf = 0; r.both = 0;
        r.lru_wb = 1'b0; r.lru_rf = 1'b0; r.wa = '0; r.ra = '0; r.hit = 2'b00; r.done = 1'b0;
        sram_en = 1'b1; sram_addr = addr; sram_wen = wen;
        for (int cyc = 0; cyc < 200 && !r.done; cyc++) begin
            wr_ack = wr_req && (wcnt == wdly);
            rd_ack = rd_req && (rcnt == rdly);
            #4;
            if (stallreq) r.stall++;
            else begin
                r.hit  = hit;
                r.done = 1'b1;
            end
            if (write_back) begin r.wb++; r.lru_wb = lru; end
            if (wr_req) begin wcnt++; r.wa = wr_addr; end
            if (rd_req) begin rcnt++; r.ra = rd_addr; end
            if (refresh) begin r.rf++; r.lru_rf = lru; end
            if (wr_req && rd_req) r.both++;
            if (write_back && refresh) r.both++;
            @(posedge clk);
            #1;
        end
        r.wrq = wcnt;
        sram_en = 1'b0; sram_wen = 4'h0; wr_ack = 1'b0; rd_ack = 1'b0;
        chk($sformatf("done_%h", addr), {31'b0, r.done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   stall_cnt;

        rst = 1'b1; sram_en = 1'b0; sram_wen = 4'h0; sram_addr = '0;
        wr_ack = 1'b0; rd_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, cold miss on 0x1040 with rd_ack 4 cycles after rd_req,
        // replay hit, store hit, uncached access, stray acks in IDLE.
        //              en wen   addr          wa rk  st hit  lru c wb rf wq rq  wa  ra
        vecs.push_back(mk(0, 4'h0, 32'h0000_0000, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 32'h0000_1040, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 32'h0000_1040, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 1, 0, 32'h0000_1040));
        vecs.push_back(mk(1, 4'h0, 32'h0000_1040, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 1, 0, 32'h0000_1040));
        vecs.push_back(mk(1, 4'h0, 32'h0000_1040, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 1, 0, 32'h0000_1040));
        vecs.push_back(mk(1, 4'h0, 32'h0000_1040, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 1, 0, 32'h0000_1040));
        vecs.push_back(mk(1, 4'h0, 32'h0000_1040, 0, 1, 1, 2'b00, 0, 1, 0, 1, 0, 1, 0, 32'h0000_1040));
        vecs.push_back(mk(1, 4'h0, 32'h0000_1040, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 32'h0000_1040));
        vecs.push_back(mk(1, 4'hF, 32'h0000_1048, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 32'h0000_1040));
        vecs.push_back(mk(1, 4'h0, 32'hBFC0_0000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1040));
        vecs.push_back(mk(1, 4'h0, 32'h0000_1040, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 32'h0000_1040));
        vecs.push_back(mk(0, 4'h0, 32'h0000_0000, 1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 32'h0000_1040));

        stall_cnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            sram_en = vecs[i].en; sram_wen = vecs[i].wen; sram_addr = vecs[i].addr;
            wr_ack = vecs[i].wack; rd_ack = vecs[i].rack;
            #4;
            if (stallreq) stall_cnt++;
            chk($sformatf("v%0d_stall", i), {31'b0, stallreq}, {31'b0, vecs[i].stall});
            chk($sformatf("v%0d_hit", i), {30'b0, hit}, {30'b0, vecs[i].hit});
            chk($sformatf("v%0d_lru", i), {31'b0, lru}, {31'b0, vecs[i].lru});
            chk($sformatf("v%0d_cached", i), {31'b0, cached}, {31'b0, vecs[i].cached});
            chk($sformatf("v%0d_wb", i), {31'b0, write_back}, {31'b0, vecs[i].wb});
            chk($sformatf("v%0d_refresh", i), {31'b0, refresh}, {31'b0, vecs[i].rf});
            chk($sformatf("v%0d_wr_req", i), {31'b0, wr_req}, {31'b0, vecs[i].wrq});
            chk($sformatf("v%0d_rd_req", i), {31'b0, rd_req}, {31'b0, vecs[i].rdq});
            chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].wa);
            chk($sformatf("v%0d_rd_addr", i), rd_addr, vecs[i].ra);
            @(posedge clk);
            #1;
        end
        wr_ack = 1'b0; rd_ack = 1'b0;
        chk("cold_stall_cycles", stall_cnt, 32'd6);

        // Fill way1 of set 1 (clean miss, victim way1 since way0 was used last).
        run_req(32'h0000_2040, 4'h0, 0, 1, r);
        chk("fill2_stall", r.stall, 32'd3);
        chk("fill2_wb", r.wb, 32'd0);
        chk("fill2_wrq", r.wrq, 32'd0);
        chk("fill2_ra", r.ra, 32'h0000_2040);
        chk("fill2_lru_rf", {31'b0, r.lru_rf}, 32'd1);
        chk("fill2_hit", {30'b0, r.hit}, 32'd2);

        // Dirty eviction of way0 (tag 1, stored to earlier).
        run_req(32'h0000_3040, 4'h0, 2, 0, r);
        chk("evict3_stall", r.stall, 32'd6);
        chk("evict3_wb", r.wb, 32'd1);
        chk("evict3_lru_wb", {31'b0, r.lru_wb}, 32'd0);
        chk("evict3_wrq_cycles", r.wrq, 32'd3);
        chk("evict3_wa", r.wa, 32'h0000_1040);
        chk("evict3_ra", r.ra, 32'h0000_3040);
        chk("evict3_rf", r.rf, 32'd1);
        chk("evict3_lru_rf", {31'b0, r.lru_rf}, 32'd0);
        chk("evict3_overlap", r.both, 32'd0);
        chk("evict3_hit", {30'b0, r.hit}, 32'd1);

        // Clean eviction of way1 (tag 2), then of way0 (tag 3 must be clean).
        run_req(32'h0000_4040, 4'h0, 0, 0, r);
        chk("evict4_stall", r.stall, 32'd2);
        chk("evict4_wb", r.wb, 32'd0);
        chk("evict4_wrq", r.wrq, 32'd0);
        chk("evict4_lru_rf", {31'b0, r.lru_rf}, 32'd1);
        chk("evict4_hit", {30'b0, r.hit}, 32'd2);
        run_req(32'h0000_5040, 4'h0, 0, 0, r);
        chk("evict5_wb", r.wb, 32'd0);
        chk("evict5_wrq", r.wrq, 32'd0);
        chk("evict5_lru_rf", {31'b0, r.lru_rf}, 32'd0);
        chk("evict5_ra", r.ra, 32'h0000_5040);
        chk("evict5_hit", {30'b0, r.hit}, 32'd1);

        // Make both ways dirty; way0 (0x5040) becomes the victim.
        run_req(32'h0000_5040, 4'hF, 0, 0, r);
        chk("st5_stall", r.stall, 32'd0);
        chk("st5_hit", {30'b0, r.hit}, 32'd1);
        run_req(32'h0000_4040, 4'h3, 0, 0, r);
        chk("st4_stall", r.stall, 32'd0);
        chk("st4_hit", {30'b0, r.hit}, 32'd2);

        // Reset while in WB_REQ.
        sram_en = 1'b1; sram_addr = 32'h0000_6040; sram_wen = 4'h0;
        #4;
        chk("rwb_detect_stall", {31'b0, stallreq}, 32'd1);
        chk("rwb_detect_lru", {31'b0, lru}, 32'd0);
        @(posedge clk); #1; #4;
        chk("rwb_wbread", {31'b0, write_back}, 32'd1);
        @(posedge clk); #1; #4;
        chk("rwb_wrreq", {31'b0, wr_req}, 32'd1);
        chk("rwb_wa", wr_addr, 32'h0000_5040);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sram_addr = 32'h0000_5040;
        #4;
        chk("rwb_after_wr_req", {31'b0, wr_req}, 32'd0);
        chk("rwb_after_rd_req", {31'b0, rd_req}, 32'd0);
        chk("rwb_after_wb", {31'b0, write_back}, 32'd0);
        chk("rwb_after_hit", {30'b0, hit}, 32'd0);
        chk("rwb_after_stall", {31'b0, stallreq}, 32'd1);
        chk("rwb_after_lru", {31'b0, lru}, 32'd0);
        chk("rwb_after_wa", wr_addr, 32'd0);
        chk("rwb_after_ra", rd_addr, 32'd0);
        @(posedge clk); #1;
        rd_ack = 1'b1;
        #4;
        chk("rwb_refill_rd_req", {31'b0, rd_req}, 32'd1);
        chk("rwb_refill_wb", {31'b0, write_back}, 32'd0);
        chk("rwb_refill_refresh", {31'b0, refresh}, 32'd1);
        chk("rwb_refill_ra", rd_addr, 32'h0000_5040);
        @(posedge clk); #1;
        rd_ack = 1'b0;
        #4;
        chk("rwb_replay_hit", {30'b0, hit}, 32'd1);
        chk("rwb_replay_stall", {31'b0, stallreq}, 32'd0);
        @(posedge clk); #1;
        sram_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
